// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary constants: payload widths, CTRL field layout and NOP encodings.
package pipe_pkg;

    localparam int PIPE_CTRL_W   = 16;
    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_DATA_W  = 96;
    localparam int EX_MEM_DATA_W = 96;
    localparam int MEM_WB_DATA_W = 64;

    localparam int CTRL_ALU_OP_LSB           = 0;
    localparam int CTRL_ALU_OP_W             = 4;
    localparam int CTRL_BRANCH_JUMP_LSB      = 4;
    localparam int CTRL_BRANCH_JUMP_W        = 2;
    localparam int CTRL_OP_SEL_LSB           = 6;
    localparam int CTRL_OP_SEL_W             = 2;
    localparam int CTRL_MEM_WRITE_BIT        = 8;
    localparam int CTRL_MEM_READ_BIT         = 9;
    localparam int CTRL_REG_WRITE_SEL_LSB    = 10;
    localparam int CTRL_REG_WRITE_SEL_W      = 2;
    localparam int CTRL_REG_WRITE_ENABLE_BIT = 12;
    localparam int CTRL_IS_LOAD_BIT          = 13;

    // All-zero CTRL means no register write and no memory access at every boundary.
    localparam logic [PIPE_CTRL_W-1:0] IF_ID_CTRL_NOP  = '0;
    localparam logic [PIPE_CTRL_W-1:0] ID_EX_CTRL_NOP  = '0;
    localparam logic [PIPE_CTRL_W-1:0] EX_MEM_CTRL_NOP = '0;
    localparam logic [PIPE_CTRL_W-1:0] MEM_WB_CTRL_NOP = '0;

    function automatic logic ctrl_has_side_effect(input logic [PIPE_CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEM_WRITE_BIT] | ctrl[CTRL_MEM_READ_BIT] | ctrl[CTRL_REG_WRITE_ENABLE_BIT];
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid + DATA + CTRL. Clear wins over load; clearing keeps DATA and forces CTRL to NOP.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = ID_EX_DATA_W,
    parameter int                CTRL_W   = PIPE_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (clear) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_NOP;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = d_data;
            ctrl_d  = d_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= CTRL_NOP;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage register: valid/ready handshake, optional skid slot, flush-to-bubble, stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = ID_EX_DATA_W,
    parameter int                CTRL_W   = PIPE_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_NOP = ID_EX_CTRL_NOP,
    parameter int                SKID     = 1,
    parameter int                CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic [CTRL_W-1:0] IN_CTRL,
    input  logic              FLUSH,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [CTRL_W-1:0] OUT_CTRL,
    output logic [CNT_W-1:0]  STALL_CNT,
    output logic [1:0]        OCCUPANCY
);

    logic              m_valid, s_valid;
    logic [DATA_W-1:0] m_data, s_data, m_src_data;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_src_ctrl;
    logic              xfer_in, pop;
    logic              m_load, m_clear, s_load, s_clear, s_valid_nxt;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    // in_ready_q is 0 in reset and rises at the first edge after release.
    assign IN_READY = (SKID != 0) ? in_ready_q : (in_ready_q & (~m_valid | OUT_READY));

    always_comb begin
        xfer_in     = IN_VALID & IN_READY;
        pop         = m_valid & OUT_READY;
        m_load      = (~m_valid | pop) & (s_valid | xfer_in);
        m_clear     = FLUSH | (pop & ~s_valid & ~xfer_in);
        m_src_data  = s_valid ? s_data : IN_DATA;
        m_src_ctrl  = s_valid ? s_ctrl : IN_CTRL;
        s_load      = (SKID != 0) & m_valid & ~pop & xfer_in;
        s_clear     = FLUSH | (pop & s_valid);
        s_valid_nxt = s_clear ? 1'b0 : (s_load ? 1'b1 : s_valid);
        in_ready_d  = ~s_valid_nxt;
        stall_cnt_d = stall_cnt_q;
        if (m_valid && !OUT_READY && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            in_ready_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_NOP(CTRL_NOP)) u_main (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .load   (m_load),
        .clear  (m_clear),
        .d_data (m_src_data),
        .d_ctrl (m_src_ctrl),
        .valid  (m_valid),
        .data   (m_data),
        .ctrl   (m_ctrl)
    );

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_NOP(CTRL_NOP)) u_skid (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .load   (s_load),
        .clear  (s_clear),
        .d_data (IN_DATA),
        .d_ctrl (IN_CTRL),
        .valid  (s_valid),
        .data   (s_data),
        .ctrl   (s_ctrl)
    );

    assign OUT_VALID = m_valid;
    assign OUT_DATA  = m_data;
    assign OUT_CTRL  = m_ctrl;
    assign STALL_CNT = stall_cnt_q;
    assign OCCUPANCY = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: SKID=1 main instance, CNT_W=4 shadow instance, SKID=0 instance.
module tb_pipe_stage_reg;

    localparam logic [15:0] NOP = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, flush, out_ready;
    logic [95:0] in_data;
    logic [15:0] in_ctrl;
    logic        in_ready, out_valid;
    logic [95:0] out_data;
    logic [15:0] out_ctrl;
    logic [15:0] stall_cnt;
    logic [1:0]  occ;

    logic        c_in_ready, c_out_valid;
    logic [95:0] c_out_data;
    logic [15:0] c_out_ctrl;
    logic [3:0]  c_stall;
    logic [1:0]  c_occ;

    logic        z_in_valid, z_out_ready, z_flush;
    logic [95:0] z_in_data;
    logic [15:0] z_in_ctrl;
    logic        z_in_ready, z_out_valid;
    logic [95:0] z_out_data;
    logic [15:0] z_out_ctrl;
    logic [15:0] z_stall;
    logic [1:0]  z_occ;

    int total = 0;
    int bad   = 0;
    logic [95:0] exp_d[$];
    logic [15:0] exp_c[$];
    logic [95:0] mon_d;
    logic [15:0] mon_c;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(96), .CTRL_W(16), .CTRL_NOP(16'h0000), .SKID(1), .CNT_W(16)) dut (
        .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
        .IN_DATA(in_data), .IN_CTRL(in_ctrl), .FLUSH(flush), .OUT_VALID(out_valid),
        .OUT_READY(out_ready), .OUT_DATA(out_data), .OUT_CTRL(out_ctrl),
        .STALL_CNT(stall_cnt), .OCCUPANCY(occ)
    );

    pipe_stage_reg #(.DATA_W(96), .CTRL_W(16), .CTRL_NOP(16'h0000), .SKID(1), .CNT_W(4)) dut_c (
        .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid), .IN_READY(c_in_ready),
        .IN_DATA(in_data), .IN_CTRL(in_ctrl), .FLUSH(flush), .OUT_VALID(c_out_valid),
        .OUT_READY(out_ready), .OUT_DATA(c_out_data), .OUT_CTRL(c_out_ctrl),
        .STALL_CNT(c_stall), .OCCUPANCY(c_occ)
    );

    pipe_stage_reg #(.DATA_W(96), .CTRL_W(16), .CTRL_NOP(16'h0000), .SKID(0), .CNT_W(16)) dut_z (
        .CLK(clk), .RESET_N(rst_n), .IN_VALID(z_in_valid), .IN_READY(z_in_ready),
        .IN_DATA(z_in_data), .IN_CTRL(z_in_ctrl), .FLUSH(z_flush), .OUT_VALID(z_out_valid),
        .OUT_READY(z_out_ready), .OUT_DATA(z_out_data), .OUT_CTRL(z_out_ctrl),
        .STALL_CNT(z_stall), .OCCUPANCY(z_occ)
    );

    function automatic logic [15:0] cfor(input logic [7:0] d);
        return 16'h1000 | {8'h00, d};
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold the word on the input until the DUT takes it; keep=1 means it must later leave the stage.
    task automatic send(input logic [95:0] d, input bit keep);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = cfor(d[7:0]);
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 for data %0h", d);
        end else if (keep) begin
            exp_d.push_back(d);
            exp_c.push_back(cfor(d[7:0]));
        end
        tick();
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_d.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon_unexpected: got data %0h expected no output", out_data);
            end else begin
                mon_d = exp_d.pop_front();
                mon_c = exp_c.pop_front();
                chk("mon_data", out_data, mon_d);
                chk("mon_ctrl", 96'(out_ctrl), 96'(mon_c));
            end
        end else if (!out_valid) begin
            chk("bubble_ctrl", 96'(out_ctrl), 96'(NOP));
        end
    end

    initial begin
        int n;
        rst_n = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0; flush = 1'b0; out_ready = 1'b0;
        z_in_valid = 1'b0; z_in_data = '0; z_in_ctrl = '0; z_out_ready = 1'b0; z_flush = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 96'(in_ready), 96'(0));
        chk("rst_out_valid", 96'(out_valid), 96'(0));
        chk("rst_out_ctrl", 96'(out_ctrl), 96'(NOP));
        chk("rst_out_data", out_data, 96'(0));
        chk("rst_stall", 96'(stall_cnt), 96'(0));
        chk("rst_occ", 96'(occ), 96'(0));
        tick();
        tick();
        rst_n = 1'b1;
        chk("ready_before_edge", 96'(in_ready), 96'(0));
        tick();
        chk("ready_after_edge", 96'(in_ready), 96'(1));

        // streaming
        out_ready = 1'b1;
        send(96'h1, 1'b1);
        chk("s1_valid", 96'(out_valid), 96'(1));
        chk("s1_data", out_data, 96'h1);
        send(96'h2, 1'b1);
        chk("s2_data", out_data, 96'h2);
        send(96'h3, 1'b1);
        chk("s3_data", out_data, 96'h3);
        chk("s3_occ", 96'(occ), 96'(1));
        chk("s_stall", 96'(stall_cnt), 96'(0));
        tick();
        chk("s_end_valid", 96'(out_valid), 96'(0));
        chk("s_end_occ", 96'(occ), 96'(0));

        // backpressure into the skid slot
        out_ready = 1'b0;
        send(96'h10, 1'b1);
        chk("bp_occ1", 96'(occ), 96'(1));
        send(96'h20, 1'b1);
        chk("bp_occ2", 96'(occ), 96'(2));
        chk("bp_full_ready", 96'(in_ready), 96'(0));
        in_valid = 1'b1; in_data = 96'h30; in_ctrl = cfor(8'h30);
        tick();
        tick();
        chk("bp_hold_data", out_data, 96'h10);
        chk("bp_hold_occ", 96'(occ), 96'(2));
        chk("bp_hold_ready", 96'(in_ready), 96'(0));
        chk("bp_stall", 96'(stall_cnt), 96'(3));
        chk("bp_stall_c", 96'(c_stall), 96'(3));
        out_ready = 1'b1;
        tick();
        chk("sim_in_ready", 96'(in_ready), 96'(1));
        chk("sim_occ", 96'(occ), 96'(1));
        chk("sim_data", out_data, 96'h20);
        exp_d.push_back(96'h30);
        exp_c.push_back(cfor(8'h30));
        tick();
        in_valid = 1'b0;
        chk("bp_c_data", out_data, 96'h30);
        chk("bp_c_occ", 96'(occ), 96'(1));
        tick();
        chk("bp_drained", 96'(occ), 96'(0));
        chk("bp_stall_final", 96'(stall_cnt), 96'(3));

        // flush with both slots held, then flush while a transfer in is offered
        out_ready = 1'b0;
        send(96'h50, 1'b0);
        send(96'h60, 1'b0);
        chk("fl_occ2", 96'(occ), 96'(2));
        in_valid = 1'b1; in_data = 96'h40; in_ctrl = cfor(8'h40); flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", 96'(out_valid), 96'(0));
        chk("fl_ctrl", 96'(out_ctrl), 96'(NOP));
        chk("fl_occ", 96'(occ), 96'(0));
        chk("fl_ready", 96'(in_ready), 96'(1));
        chk("fl_stall", 96'(stall_cnt), 96'(5));
        send(96'h51, 1'b0);
        in_valid = 1'b1; in_data = 96'h41; in_ctrl = cfor(8'h41); flush = 1'b1;
        chk("fl2_ready_pre", 96'(in_ready), 96'(1));
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl2_occ", 96'(occ), 96'(0));
        chk("fl2_valid", 96'(out_valid), 96'(0));
        chk("fl2_stall", 96'(stall_cnt), 96'(6));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        chk("empty_pulse_occ", 96'(occ), 96'(0));
        chk("empty_pulse_valid", 96'(out_valid), 96'(0));

        // stall counter saturation on the CNT_W=4 instance
        send(96'h70, 1'b1);
        repeat (20) tick();
        chk("sat_c", 96'(c_stall), 96'(15));
        chk("sat_main", 96'(stall_cnt), 96'(26));
        out_ready = 1'b1;
        tick();
        chk("sat_c_hold", 96'(c_stall), 96'(15));
        chk("sat_occ", 96'(occ), 96'(0));

        // asynchronous reset mid-stall
        out_ready = 1'b0;
        send(96'h80, 1'b0);
        send(96'h90, 1'b0);
        chk("ar_occ_pre", 96'(occ), 96'(2));
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 96'(out_valid), 96'(0));
        chk("ar_ctrl", 96'(out_ctrl), 96'(NOP));
        chk("ar_data", out_data, 96'(0));
        chk("ar_stall", 96'(stall_cnt), 96'(0));
        chk("ar_stall_c", 96'(c_stall), 96'(0));
        chk("ar_occ", 96'(occ), 96'(0));
        chk("ar_ready", 96'(in_ready), 96'(0));
        rst_n = 1'b1;
        tick();
        chk("ar_ready_back", 96'(in_ready), 96'(1));

        // single-slot instance: combinational ready, one-cycle latency
        z_in_valid = 1'b1; z_in_data = 96'h5; z_in_ctrl = cfor(8'h05);
        #1;
        chk("z_ready_empty", 96'(z_in_ready), 96'(1));
        tick();
        chk("z_valid", 96'(z_out_valid), 96'(1));
        chk("z_data5", z_out_data, 96'h5);
        chk("z_full_ready", 96'(z_in_ready), 96'(0));
        chk("z_occ", 96'(z_occ), 96'(1));
        tick();
        chk("z_hold5", z_out_data, 96'h5);
        chk("z_stall", 96'(z_stall), 96'(1));
        z_out_ready = 1'b1; z_in_data = 96'h6; z_in_ctrl = cfor(8'h06);
        #1;
        chk("z_ready_comb", 96'(z_in_ready), 96'(1));
        tick();
        chk("z_data6", z_out_data, 96'h6);
        chk("z_ctrl6", 96'(z_out_ctrl), 96'(cfor(8'h06)));
        chk("z_occ6", 96'(z_occ), 96'(1));
        z_in_valid = 1'b0;
        tick();
        chk("z_end_valid", 96'(z_out_valid), 96'(0));
        chk("z_end_ctrl", 96'(z_out_ctrl), 96'(NOP));
        chk("z_end_occ", 96'(z_occ), 96'(0));

        n = 0;
        while (exp_d.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("queue_drained", 96'(exp_d.size()), 96'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
